p64_1block_scan: RTL and testbench

// - Single-cache-line filter scan for the 8-bit column encoding.
// - Splits one 512-bit CCI-P read-response line into 64 unsigned 8-bit values.
// - Compares every value against the query predicate and registers a 64-bit match mask.
// - Sits behind the AFU read-response path. It is enabled for one cycle per response.
//   The AFU copies the mask to a CPU-readable CSR on the following cycle.

---
 rtl/p64_scan_pkg.sv | 23 ++
 rtl/p64_1block_scan_if.sv | 31 +++
 rtl/p64_lane_cmp.sv | 12 +
 rtl/p64_1block_scan.sv | 69 ++++++
 tb/tb_p64_1block_scan.sv | 139 +++++++++++++
 5 files changed

// File: rtl/p64_scan_pkg.sv
// Shared types and sizing for the 64-lane, 8-bit single-cache-line filter scan.
// Optional popcount output is controlled by the P64_SCAN_POPCOUNT_EN macro.
package p64_scan_pkg;

  localparam int LANES    = 64;
  localparam int LANE_W   = 8;
  localparam int CL_W     = 512;
  localparam int PRED_W   = 32;
  localparam int CNT_W    = $clog2(LANES + 1);
  localparam int CL_IDX_W = $clog2(CL_W);

  typedef logic [LANE_W-1:0] t_lane;
  typedef logic [LANES-1:0]  t_mask;
  typedef logic [CL_W-1:0]   t_cl;

  // Lane idx occupies bits [idx*LANE_W +: LANE_W] of the cache line.
  function automatic t_lane lane_of(input t_cl cl, input int idx);
    logic [CL_IDX_W-1:0] base;
    base = CL_IDX_W'(idx * LANE_W);
    return cl[base +: LANE_W];
  endfunction

endpackage

// File: rtl/p64_1block_scan_if.sv
// Read-response side bundle of the filter scan: line/predicate in, mask/valid out.
// match_count is present only when P64_SCAN_POPCOUNT_EN is defined.
interface p64_1block_scan_if;
  import p64_scan_pkg::*;

  logic              en;
  t_cl               incoming_cl;
  logic [PRED_W-1:0] predicate;
  t_mask             bit_result;
  logic              result_valid;
`ifdef P64_SCAN_POPCOUNT_EN
  logic [CNT_W-1:0]  match_count;
`endif

  modport master (
    output en, incoming_cl, predicate,
`ifdef P64_SCAN_POPCOUNT_EN
    input  match_count,
`endif
    input  bit_result, result_valid
  );

  modport slave (
    input  en, incoming_cl, predicate,
`ifdef P64_SCAN_POPCOUNT_EN
    output match_count,
`endif
    output bit_result, result_valid
  );

endinterface

// File: rtl/p64_lane_cmp.sv
// One lane of the scan: unsigned value < predicate, purely combinational.
module p64_lane_cmp
  import p64_scan_pkg::*;
(
  input  t_lane value,
  input  t_lane pred,
  output logic  match
);

  assign match = (value < pred);

endmodule

// File: rtl/p64_1block_scan.sv
// Single-cache-line filter scan: 64 parallel lane compares into a registered match mask.
// Build with P64_SCAN_POPCOUNT_EN to add a registered population count of the mask.
module p64_1block_scan
  import p64_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  p64_1block_scan_if.slave bus
);

  t_lane pred_lane;
  t_mask mask_next;
  t_mask bit_result_reg;
  logic  result_valid_reg;

  // Only the low lane-width bits of the predicate take part in the compare.
  logic [PRED_W-LANE_W-1:0] unused_pred_hi;
  assign pred_lane      = bus.predicate[LANE_W-1:0];
  assign unused_pred_hi = bus.predicate[PRED_W-1:LANE_W];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      p64_lane_cmp u_cmp (
        .value (lane_of(bus.incoming_cl, gi)),
        .pred  (pred_lane),
        .match (mask_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_result_reg   <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      result_valid_reg <= bus.en;
      if (bus.en) begin
        bit_result_reg <= mask_next;
      end
    end
  end

  assign bus.bit_result   = bit_result_reg;
  assign bus.result_valid = result_valid_reg;

`ifdef P64_SCAN_POPCOUNT_EN
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_reg;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < LANES; i++) begin
      count_next = count_next + CNT_W'(mask_next[i]);
    end
  end

  // Counts the same mask that lands in bit_result, on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (bus.en) begin
      count_reg <= count_next;
    end
  end

  assign bus.match_count = count_reg;
`endif

endmodule

// File: tb/tb_p64_1block_scan.sv
// Directed self-checking bench for p64_1block_scan (define P64_SCAN_POPCOUNT_EN to check match_count).
module tb_p64_1block_scan;
  import p64_scan_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  p64_1block_scan_if bus ();

  p64_1block_scan dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic en_v, input t_cl cl, input logic [31:0] pred);
    @(negedge clk);
    bus.en          = en_v;
    bus.incoming_cl = cl;
    bus.predicate   = pred;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [63:0] mask, input logic valid);
    check_eq({tag, "_mask"}, bus.bit_result, mask);
    check_eq({tag, "_valid"}, {63'd0, bus.result_valid}, {63'd0, valid});
  endtask

  task automatic check_cnt(input string tag, input int cnt);
`ifdef P64_SCAN_POPCOUNT_EN
    check_eq({tag, "_count"}, {57'd0, bus.match_count}, 64'(cnt));
`endif
  endtask

  t_cl ramp, rramp, all80, alt_ff, grp81, rnd;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < LANES; i++) begin
      ramp [i*8 +: 8] = 8'(i);
      rramp[i*8 +: 8] = 8'(63 - i);
      all80[i*8 +: 8] = 8'h80;
      alt_ff[i*8 +: 8] = (i % 2 == 0) ? 8'h00 : 8'hFF;
      grp81[i*8 +: 8] = ((i % 8 == 0) || (i % 8 == 7)) ? 8'h00 : 8'hFF;
      rnd  [i*8 +: 8] = 8'($urandom);
    end

    // Reset held with en active and live data
    reset           = 1'b0;
    bus.en          = 1'b1;
    bus.incoming_cl = rnd;
    bus.predicate   = 32'hFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_out("reset_hold", 64'd0, 1'b0);
      check_cnt("reset_hold", 0);
    end
    @(negedge clk);
    reset  = 1'b1;
    bus.en = 1'b0;

    // Basic compare
    cycle(1'b1, ramp, 32'd10);
    check_out("basic", 64'h0000_0000_0000_03FF, 1'b1);
    check_cnt("basic", 10);
    cycle(1'b0, ramp, 32'd10);
    check_out("basic_after", 64'h0000_0000_0000_03FF, 1'b0);

    // Equality and upper predicate bits ignored
    cycle(1'b1, all80, 32'hFFFF_FF80);
    check_out("equal", 64'd0, 1'b1);
    cycle(1'b1, all80, 32'h81);
    check_out("all_match", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check_cnt("all_match", 64);

    // Extremes
    cycle(1'b1, rnd, 32'h0);
    check_out("pred_zero", 64'd0, 1'b1);
    check_cnt("pred_zero", 0);
    cycle(1'b1, alt_ff, 32'hFF);
    check_out("pred_ff", 64'h5555_5555_5555_5555, 1'b1);
    check_cnt("pred_ff", 32);

    // Back-to-back, then hold
    cycle(1'b1, ramp, 32'd32);
    check_out("b2b_1", 64'h0000_0000_FFFF_FFFF, 1'b1);
    cycle(1'b1, rramp, 32'd8);
    check_out("b2b_2", 64'hFF00_0000_0000_0000, 1'b1);
    cycle(1'b1, grp81, 32'd1);
    check_out("b2b_3", 64'h8181_8181_8181_8181, 1'b1);
    check_cnt("b2b_3", 16);
    cycle(1'b0, rnd, 32'hFF);
    check_out("hold_1", 64'h8181_8181_8181_8181, 1'b0);
    cycle(1'b0, ramp, 32'h40);
    check_out("hold_2", 64'h8181_8181_8181_8181, 1'b0);
    check_cnt("hold_2", 16);

    // Reset mid-stream clears outputs without waiting for a clock edge
    cycle(1'b1, ramp, 32'd10);
    check_out("pre_rst", 64'h0000_0000_0000_03FF, 1'b1);
    @(negedge clk);
    bus.en = 1'b1;
    reset  = 1'b0;
    #1;
    check_out("async_rst", 64'd0, 1'b0);
    check_cnt("async_rst", 0);
    @(posedge clk);
    #1;
    check_out("rst_held", 64'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, ramp, 32'd10);
    check_out("post_rst", 64'h0000_0000_0000_03FF, 1'b1);
    check_cnt("post_rst", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
